// File: rtl/sd_mul_pkg.sv
// Shared definitions for the radix-4 signed-digit multiply sequencer:
// FSM state codes and the 3-bit two's-complement digit encodings.
package sd_mul_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int SD_W = 3;

    localparam logic [SD_W-1:0] D_M2 = 3'b110;
    localparam logic [SD_W-1:0] D_M1 = 3'b111;
    localparam logic [SD_W-1:0] D_0  = 3'b000;
    localparam logic [SD_W-1:0] D_P1 = 3'b001;
    localparam logic [SD_W-1:0] D_P2 = 3'b010;

endpackage

// File: rtl/sd4_recode.sv
// Combinational radix-4 recoder: turns a W-bit two's-complement multiplier
// into W/2 signed digits in -2..+2, digit 0 in the least significant slot.
module sd4_recode
    import sd_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]            b,
    output logic [(W/2)*SD_W-1:0]   digits
);

    localparam int ND = W / 2;

    logic [W:0] w_bExt;

    // Appending a zero below bit 0 supplies b[-1], so each digit reads one overlapping triple.
    assign w_bExt = {b, 1'b0};

    always_comb begin
        digits = '0;
        for (int i = 0; i < ND; i++) begin
            case (w_bExt[2*i +: 3])
                3'b001, 3'b010: digits[i*SD_W +: SD_W] = D_P1;
                3'b011:         digits[i*SD_W +: SD_W] = D_P2;
                3'b100:         digits[i*SD_W +: SD_W] = D_M2;
                3'b101, 3'b110: digits[i*SD_W +: SD_W] = D_M1;
                default:        digits[i*SD_W +: SD_W] = D_0;
            endcase
        end
    end

endmodule

// File: rtl/sd_mul_seq.sv
// Multi-cycle signed multiplier consuming one radix-4 digit per clock.
// Define SD_MUL_EARLY_EXIT_EN to finish as soon as the remaining digits are all zero.
module sd_mul_seq
    import sd_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic              busy,
    output logic              done,
    output logic [2*W-1:0]    product
);

    localparam int ND = W / 2;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam int AW = 2 * W;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic [AW-1:0]          r_acc;
    logic [AW-1:0]          r_product;
    logic [CW-1:0]          r_cnt;
    logic [ND*SD_W-1:0]     w_digits;
    logic [SD_W-1:0]        w_digit;
    logic [AW-1:0]          w_aExt;
    logic [AW-1:0]          w_pp;
    logic [AW-1:0]          w_accNext;
    logic                   w_lastDigit;

    sd4_recode #(.W(W)) u_recode (
        .b      (r_b),
        .digits (w_digits)
    );

    assign w_digit   = w_digits[r_cnt*SD_W +: SD_W];
    assign w_aExt    = {{W{r_a[W-1]}}, r_a};
    assign w_accNext = r_acc + (w_pp << {r_cnt, 1'b0});

    // Digit magnitudes are only 1 or 2, so a shift and a negate replace a multiplier.
    always_comb begin
        case (w_digit)
            D_P1:    w_pp = w_aExt;
            D_P2:    w_pp = w_aExt << 1;
            D_M1:    w_pp = -w_aExt;
            D_M2:    w_pp = -(w_aExt << 1);
            default: w_pp = '0;
        endcase
    end

`ifdef SD_MUL_EARLY_EXIT_EN
    always_comb begin
        w_lastDigit = 1'b1;
        for (int j = 0; j < ND; j++) begin
            if (j > int'(r_cnt) && w_digits[j*SD_W +: SD_W] != D_0) begin
                w_lastDigit = 1'b0;
            end
        end
    end
`else
    assign w_lastDigit = (r_cnt == CW'(ND - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (w_lastDigit) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The finished sum is shown directly during DONE so product is valid alongside done.
    always_comb begin
        busy    = (r_state != IDLE);
        done    = (r_state == DONE);
        product = (r_state == DONE) ? r_acc : r_product;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_acc <= w_accNext;
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_product <= r_acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_mul_seq.sv
// Self-checking bench for sd_mul_seq: directed vector table, multi-cycle corner
// sequences and random operands against an arithmetic reference model.
module tb_sd_mul_seq;

    localparam int W  = 8;
    localparam int ND = W / 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              busy;
    logic              done;
    logic [2*W-1:0]    product;

    int testsRun;
    int testsFailed;

    typedef struct {
        int     va;
        int     vb;
        longint expProd;
        string  name;
    } vector_t;

    vector_t vectors[10];

    sd_mul_seq #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency from the digit rule: highest nonzero digit + 2 with early exit, else ND + 1.
    function automatic int modelLatency(input logic [W-1:0] bv);
`ifdef SD_MUL_EARLY_EXIT_EN
        int hi;
        int bu;
        int d;
        hi = 0;
        bu = int'(bv);
        for (int i = 0; i < ND; i++) begin
            d = -2 * ((bu >> (2*i + 1)) & 1) + ((bu >> (2*i)) & 1);
            if (i > 0) d = d + ((bu >> (2*i - 1)) & 1);
            if (d != 0) hi = i;
        end
        return hi + 2;
`else
        return ND + 1 + 0 * int'(bv);
`endif
    endfunction

    function automatic longint modelProduct(input logic [W-1:0] av, input logic [W-1:0] bv);
        return longint'($signed(av)) * longint'($signed(bv));
    endfunction

    task automatic checkOutput(input string name, input longint got, input longint exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One full operation from the idle state; called at a negedge, returns at a negedge.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input string name);
        longint expProd;
        int     expLat;
        int     gotLat;
        int     cyc;
        bit     busyOk;
        expProd = modelProduct(ta, tb);
        expLat  = modelLatency(tb);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
        gotLat = -1;
        busyOk = 1'b1;
        while (cyc <= 20 && gotLat < 0) begin
            if (!busy) busyOk = 1'b0;
            if (done) begin
                gotLat = cyc;
                checkOutput({name, " product"}, longint'($signed(product)), expProd);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput({name, " latency"}, longint'(gotLat), longint'(expLat));
        checkOutput({name, " busy during op"}, longint'(busyOk), 64'd1);
        @(negedge clk);
        checkOutput({name, " idle after done"}, longint'({busy, done}), 64'd0);
        checkOutput({name, " product held"}, longint'($signed(product)), expProd);
    endtask

    initial begin
        int   lat;
        int   expDone;
        int   doneSeen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        testsRun    = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vectors[0] = '{13, 13, 169, "t1 13*13"};
        vectors[1] = '{-128, -128, 16384, "t2 min*min"};
        vectors[2] = '{127, -128, -16256, "t2 max*min"};
        vectors[3] = '{-1, 1, -1, "t2 -1*1"};
        vectors[4] = '{-128, 127, -16256, "min*max"};
        vectors[5] = '{0, 0, 0, "zero*zero"};
        vectors[6] = '{-50, 1, -50, "t6 -50*1"};
        vectors[7] = '{85, -86, -7310, "85*-86"};
        vectors[8] = '{-7, 0, 0, "b zero"};
        vectors[9] = '{2, -3, -6, "2*-3"};

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset busy", longint'(busy), 64'd0);
        checkOutput("reset done", longint'(done), 64'd0);
        checkOutput("reset product", longint'(product), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            checkOutput({vectors[i].name, " table model"},
                        modelProduct(W'(vectors[i].va), W'(vectors[i].vb)), vectors[i].expProd);
            applyStimulus(W'(vectors[i].va), W'(vectors[i].vb), vectors[i].name);
        end

        // Start held high: one result per (latency + 1) cycles.
        lat = modelLatency(W'(5));
        start = 1'b1;
        a = W'(3);
        b = W'(5);
        doneSeen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            expDone = ((c % (lat + 1)) == lat) ? 1 : 0;
            checkOutput($sformatf("t3 done at cycle %0d", c), longint'(done), longint'(expDone));
            if (done) begin
                doneSeen++;
                checkOutput("t3 product", longint'($signed(product)), 64'd15);
            end
        end
        checkOutput("t3 done count", longint'(doneSeen), longint'(20 / (lat + 1)));
        start = 1'b0;
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        checkOutput("t3 returns idle", longint'(busy), 64'd0);

        // Second start while busy must not disturb the in-flight operands.
        lat = modelLatency(W'(9));
        start = 1'b1;
        a = W'(7);
        b = W'(9);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        doneSeen = 0;
        for (int c = 1; c <= 12 && doneSeen == 0; c++) begin
            if (c >= 2) begin
                start = 1'b1;
                a = W'(100);
                b = W'(100);
            end
            if (done) begin
                doneSeen = c;
                start = 1'b0;
                checkOutput("t4 product", longint'($signed(product)), 64'd63);
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        checkOutput("t4 latency", longint'(doneSeen), longint'(lat));
        @(negedge clk);
        checkOutput("t4 idle after done", longint'(busy), 64'd0);

        // Reset in the middle of RUN discards the operation.
        start = 1'b1;
        a = W'(13);
        b = W'(13);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("t5 busy after reset", longint'(busy), 64'd0);
        checkOutput("t5 done after reset", longint'(done), 64'd0);
        checkOutput("t5 product after reset", longint'(product), 64'd0);
        doneSeen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("t5 no stray done", longint'(doneSeen), 64'd0);
        applyStimulus(W'(2), W'(-3), "t5 post-reset 2*-3");

        applyStimulus(W'(-50), W'(1), "t6 early exit");

        for (int r = 0; r < 40; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            applyStimulus(ra, rb, $sformatf("rand %0d (%0d*%0d)", r, $signed(ra), $signed(rb)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sd_mul_seq.md
Name: sd_mul_seq

Overview:
Multi-cycle signed multiplier sequencer for the Goldschmidt divider datapath.
- Recodes the multiplier operand into radix-4 signed digits (range -2..+2), least significant digit first.
- Consumes one digit per clock, accumulating shifted partial products of the multiplicand.
- Shares a single add/shift resource across W/2 cycles. The iteration controller uses it for each divisor/dividend scaling multiply.

Parameters:
- W, 8, operand width in bits; must be even and at least 4.
- ND, W/2, number of radix-4 digits; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse or level; accepted only when busy=0
- a  input  W  signed multiplicand (two's complement)
- b  input  W  signed multiplier (two's complement), recoded to digits
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle pulse; product valid on the same cycle
- product  output  2W  signed result a*b; held until the next accepted start

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal acc=0, cnt=0.
  - Reset overrides every other input, including mid-RUN; any in-flight operation is discarded with no done pulse.
- Digit rule: d_i = -2*b[2i+1] + b[2i] + b[2i-1], with b[-1]=0, for i=0..ND-1. Stored as 3-bit two's complement.
- States and transitions:
  - IDLE: if start=1, latch a_r=a and b_r=b, clear acc=0 and cnt=0, go to RUN. Otherwise stay.
  - RUN: acc <= acc + ((d_cnt * sext(a_r)) << 2*cnt), computed at 2W bits. cnt <= cnt+1. If cnt==ND-1, go to DONE; otherwise stay.
  - DONE: product <= acc; done=1 for this cycle only; go to IDLE.
- Output and handshake timing:
  - busy=1 in RUN and DONE; busy=0 in IDLE.
  - start is ignored whenever busy=1; in-flight operands are unaffected.
  - Latency: start sampled at edge 0 → done=1 in cycle ND+1 (cycle 5 for W=8).
  - Throughput with start held high: one result every ND+2 cycles.
- Arithmetic:
  - All partial sums are exact in 2W signed bits. No overflow is possible, including a=b=-2^(W-1).
  - Multiplication by ±2 is a shift of ±a_r; there is no multiplier primitive.
- Product register updates only in DONE, so product is stable between done pulses.

Optional Feature:
- Macro: SD_MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, after accumulating digit cnt, if all digits cnt+1..ND-1 are zero, go directly to DONE.
  - Latency becomes (index of highest nonzero digit)+2, minimum 2.
  - b=0 yields done at cycle 2 with product 0.
- Undefined: fixed latency of ND+1 for all operands.
- Results are identical either way.

Decomposition:
- Package sd_mul_pkg:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - digit width constant SD_W=3.
  - digit constants for -2..+2.
- Sub-module sd4_recode: combinational, input W-bit b, output ND packed 3-bit digits per the rule above. The sequencer indexes the digit at cnt.

Test Plan:
1. a=13, b=13 → digits 1,-1,1,0; done at cycle 5 after start; product=169; busy high during cycles 1..5.
2. a=-128, b=-128 → product=16384; then a=127, b=-128 → product=-16256; a=-1, b=1 → product=-1.
3. start held high for 20 cycles with a=3, b=5 → product=15; done pulses at cycles 5, 11 and 17 (period 6).
4. start with a=7, b=9, then at cycle 2 apply start=1 with a=100, b=100 → second start ignored; product=63 at cycle 5.
5. rst_n=0 for one cycle during RUN (cycle 3) → next cycle busy=0, done=0, product=0, and no done pulse. A following start with a=2, b=-3 → product=-6.
6. Early exit, b=1, a=-50:
   - with SD_MUL_EARLY_EXIT_EN defined → done at cycle 2, product=-50;
   - without it → done at cycle 5, product=-50.
